msdap_p2s_tx: RTL
=================

Name: msdap_p2s_tx

Overview:
- Output-side transmitter of the MSDAP datapath: the parallel-to-serial counterpart of the input serial-to-parallel path.
- Captures one WIDTH-bit result per channel (left/right) when the controller pulses p2s_load.
- Shifts both words out MSB-first on a per-bit strobe, with an output frame marker on the first bit.
- Reports completion, back-to-back acceptance and overrun to the control FSM.

Parameters:
- WIDTH, 40, bits per output word per channel
- CNT_W, 6, width of bit counter; must satisfy 2^CNT_W >= WIDTH

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- p2s_clear  in  1  synchronous clear from controller, same effect as reset
- p2s_load  in  1  capture data_l/data_r and start a word
- data_l  in  WIDTH  left-channel parallel result
- data_r  in  WIDTH  right-channel parallel result
- shift_en  in  1  bit strobe (one serial bit period per assertion)
- out_l  out  1  left serial bit
- out_r  out  1  right serial bit
- out_frame  out  1  high while the MSB of a word is on out_l/out_r
- busy  out  1  word in flight
- done  out  1  one-cycle pulse when last bit is consumed
- overrun  out  1  sticky: load arrived while a word was mid-flight

Behaviour:
- Reset/clear: if reset_n==0 or p2s_clear==1 at a clk edge:
  - state=IDLE, shift regs=0, bit_cnt=0.
  - out_l=out_r=out_frame=busy=done=overrun=0.
  - reset has priority over clear; clear has priority over load.
- States: IDLE, SHIFT.
- IDLE:
  - outputs 0.
  - p2s_load=1 -> sreg_l<=data_l, sreg_r<=data_r, bit_cnt<=WIDTH-1, state<=SHIFT.
  - shift_en is ignored in IDLE.
- SHIFT:
  - out_l=sreg_l[WIDTH-1], out_r=sreg_r[WIDTH-1], busy=1.
  - out_frame=1 iff bit_cnt==WIDTH-1.
  - Outputs derive from registered state only; no combinational path from inputs.
  - shift_en=1 and bit_cnt>0 -> both regs shift left by 1 (zero fill), bit_cnt decrements.
  - shift_en=0 -> hold; each bit is held an arbitrary number of cycles.
  - shift_en=1 and bit_cnt==0 (last bit):
    - done=1 in the following cycle (registered pulse, exactly 1 cycle).
    - If p2s_load=1 in the same cycle: new word captured, bit_cnt<=WIDTH-1, stay in SHIFT. Gapless back-to-back, next cycle shows new MSB with out_frame=1.
    - Else state<=IDLE.
- Latency:
  - load at edge N -> MSB and out_frame valid in cycle N+1.
  - A word occupies exactly WIDTH shift_en assertions.
- Overrun:
  - p2s_load=1 in SHIFT, except on the last-bit shift_en cycle -> load ignored, in-flight word unaffected, overrun<=1.
  - overrun is sticky until reset/clear.
- Clear mid-word: word abandoned immediately, no done pulse.
- Data inputs are sampled only at the capture edge; later changes are ignored.

Test Plan:
- Reset: hold reset_n=0 with p2s_load=1, shift_en=1 -> all outputs 0, state IDLE. Release -> still idle until next load.
- Single word: load data_l=40'h80_0000_0001, data_r=40'h00_0000_0000, shift_en=1 continuous -> out_frame=1 only in first cycle. out_l=1, 0 x38, then 1 over 40 cycles; out_r all 0. done pulses once in cycle 41; busy falls the same cycle.
- Stalled strobe: load 40'hAA_AAAA_AAAA, shift_en asserted every 3rd cycle -> each bit held 3 cycles, alternating 1/0. out_frame held for the first 3 cycles; done after the 40th strobe.
- Back-to-back: second load (data_l=40'hFF_FFFF_FFFF) on the last-bit shift_en cycle -> next cycle out_l=1 with out_frame=1, busy never drops, one done pulse. overrun stays 0.
- Overrun: load at bit_cnt==20 -> overrun=1, the remaining 20 bits match the original word. overrun remains 1 after done until p2s_clear.
- Clear mid-word: p2s_clear at bit_cnt==10 -> next cycle all outputs 0, no done. A subsequent load starts a fresh word with out_frame=1.

Source files
------------

// File: rtl/msdap_p2s_tx.sv
// Output-side parallel-to-serial transmitter for the MSDAP datapath.
// Shifts left/right words out MSB-first on shift_en, with frame, done and overrun status.
module msdap_p2s_tx #(
    parameter int WIDTH = 40,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             p2s_clear,
    input  logic             p2s_load,
    input  logic [WIDTH-1:0] data_l,
    input  logic [WIDTH-1:0] data_r,
    input  logic             shift_en,
    output logic             out_l,
    output logic             out_r,
    output logic             out_frame,
    output logic             busy,
    output logic             done,
    output logic             overrun
);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sreg_l_q, sreg_l_d;
    logic [WIDTH-1:0] sreg_r_q, sreg_r_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             done_q, done_d;
    logic             overrun_q, overrun_d;
    logic             last_strobe;

    assign last_strobe = shift_en && (bit_cnt_q == '0);

    always_comb begin
        state_d   = state_q;
        sreg_l_d  = sreg_l_q;
        sreg_r_d  = sreg_r_q;
        bit_cnt_d = bit_cnt_q;
        done_d    = 1'b0;
        overrun_d = overrun_q;

        case (state_q)
            IDLE: begin
                if (p2s_load) begin
                    sreg_l_d  = data_l;
                    sreg_r_d  = data_r;
                    bit_cnt_d = LAST_IDX;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                // A load is only legal on the strobe that consumes the final bit.
                if (p2s_load && !last_strobe) begin
                    overrun_d = 1'b1;
                end
                if (shift_en) begin
                    sreg_l_d = sreg_l_q << 1;
                    sreg_r_d = sreg_r_q << 1;
                    if (bit_cnt_q == '0) begin
                        done_d = 1'b1;
                        if (p2s_load) begin
                            sreg_l_d  = data_l;
                            sreg_r_d  = data_r;
                            bit_cnt_d = LAST_IDX;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q - CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n || p2s_clear) begin
            state_q   <= IDLE;
            sreg_l_q  <= '0;
            sreg_r_q  <= '0;
            bit_cnt_q <= '0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sreg_l_q  <= sreg_l_d;
            sreg_r_q  <= sreg_r_d;
            bit_cnt_q <= bit_cnt_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
        end
    end

    assign busy      = (state_q == SHIFT);
    assign out_l     = busy && sreg_l_q[WIDTH-1];
    assign out_r     = busy && sreg_r_q[WIDTH-1];
    assign out_frame = busy && (bit_cnt_q == LAST_IDX);
    assign done      = done_q;
    assign overrun   = overrun_q;

endmodule
